// File: rtl/repetition_detector_v2.sv
// repetition_detector_v2: takes one group of GROUP_SIZE values per handshake.
// It forwards the group with a per-lane info bitmap and per-lane back-reference
// indices, one register stage deep.
// Mode 0 flags zero lanes. Mode 1 flags lanes that repeat an earlier lane and
// points each one at the first earlier lane with the same value.
// Optional statistics counters are built when REPETITION_DETECTOR_STATS_EN is defined.
module repetition_detector_v2 #(
  parameter int DATA_WIDTH             = 8,
  parameter int GROUP_SIZE             = 4,
  parameter int LOG_GROUP              = 2,
  parameter int LOG_MAX_ITERS          = 16,
  parameter int LOG_MAX_READS_PER_ITER = 16,
  parameter int ZERO_INFO              = GROUP_SIZE
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   configure,
  input  logic                                   mode,
  input  logic [LOG_MAX_ITERS-1:0]               num_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0]      num_reads_per_iter,
  input  logic [GROUP_SIZE*DATA_WIDTH-1:0]       data_in,
  input  logic                                   valid_in,
  output logic                                   avail_out,
  output logic [GROUP_SIZE*DATA_WIDTH+ZERO_INFO-1:0] data_out,
  output logic [GROUP_SIZE*LOG_GROUP-1:0]        rep_idx_out,
  output logic                                   valid_out,
  output logic                                   last_out,
  output logic                                   done,
  input  logic                                   avail_in
`ifdef REPETITION_DETECTOR_STATS_EN
  ,
  output logic [31:0]                            stat_info_count,
  output logic [31:0]                            stat_group_count
`endif
);

  localparam int VW = GROUP_SIZE * DATA_WIDTH;
  localparam int IW = GROUP_SIZE * LOG_GROUP;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t                              state, state_next;
  logic                                mode_r;
  logic [LOG_MAX_ITERS-1:0]            iters_r;
  logic [LOG_MAX_READS_PER_ITER-1:0]   reads_r;
  logic [LOG_MAX_ITERS-1:0]            iter_cnt;
  logic [LOG_MAX_READS_PER_ITER-1:0]   read_cnt;
  logic [ZERO_INFO-1:0]                info_p0;
  logic [IW-1:0]                       idx_p0;
  logic                                accept, consume, cfg_accept;
  logic                                last_read, last_iter;

  // Info bitmap. Mode 0 marks zero lanes. Mode 1 marks lanes that equal an earlier lane.
  function automatic logic [ZERO_INFO-1:0] detect_info(input logic [VW-1:0] d, input logic m);
    logic [ZERO_INFO-1:0] info;
    info = '0;
    for (int k = 0; k < GROUP_SIZE; k++) begin
      if (!m) begin
        info[k] = (d[k*DATA_WIDTH +: DATA_WIDTH] == '0);
      end else begin
        for (int j = 0; j < k; j++) begin
          if (d[j*DATA_WIDTH +: DATA_WIDTH] == d[k*DATA_WIDTH +: DATA_WIDTH]) info[k] = 1'b1;
        end
      end
    end
    return info;
  endfunction

  // Back-reference indices. Each lane defaults to itself. In mode 1 the
  // downward scan leaves the smallest matching earlier lane in place.
  function automatic logic [IW-1:0] detect_idx(input logic [VW-1:0] d, input logic m);
    logic [IW-1:0] idx;
    idx = '0;
    for (int k = 0; k < GROUP_SIZE; k++) begin
      idx[k*LOG_GROUP +: LOG_GROUP] = LOG_GROUP'(k);
      if (m) begin
        for (int j = k - 1; j >= 0; j--) begin
          if (d[j*DATA_WIDTH +: DATA_WIDTH] == d[k*DATA_WIDTH +: DATA_WIDTH])
            idx[k*LOG_GROUP +: LOG_GROUP] = LOG_GROUP'(j);
        end
      end
    end
    return idx;
  endfunction

  assign cfg_accept = (state == IDLE) && configure;
  assign avail_out  = (state == RUN) && (!valid_out || avail_in);
  assign accept     = valid_in && avail_out;
  assign consume    = valid_out && avail_in;
  assign last_read  = (read_cnt == reads_r - LOG_MAX_READS_PER_ITER'(1));
  assign last_iter  = (iter_cnt == iters_r - LOG_MAX_ITERS'(1));
  assign done       = (state == DONE);

  // Stage 0: combinational detection on the incoming group
  always_comb begin
    info_p0 = detect_info(data_in, mode_r);
    idx_p0  = detect_idx(data_in, mode_r);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic. FLUSH drains the final group before DONE is signalled.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (configure) begin
          if (num_iters != '0 && num_reads_per_iter != '0) state_next = RUN;
          else                                             state_next = DONE;
        end
      end
      RUN:     if (accept && last_read && last_iter) state_next = FLUSH;
      FLUSH:   if (!valid_out || avail_in)           state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Configuration latch and read/iteration counters. A new configuration restarts counting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_r   <= 1'b0;
      iters_r  <= '0;
      reads_r  <= '0;
      iter_cnt <= '0;
      read_cnt <= '0;
    end else if (cfg_accept) begin
      mode_r   <= mode;
      iters_r  <= num_iters;
      reads_r  <= num_reads_per_iter;
      iter_cnt <= '0;
      read_cnt <= '0;
    end else if (accept) begin
      if (last_read) begin
        read_cnt <= '0;
        iter_cnt <= iter_cnt + LOG_MAX_ITERS'(1);
      end else begin
        read_cnt <= read_cnt + LOG_MAX_READS_PER_ITER'(1);
      end
    end
  end

  // Stage 1: output register. It loads on accept, drops valid on a bare consume, and holds otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out    <= '0;
      rep_idx_out <= '0;
      valid_out   <= 1'b0;
      last_out    <= 1'b0;
    end else if (accept) begin
      data_out    <= {info_p0, data_in};
      rep_idx_out <= idx_p0;
      valid_out   <= 1'b1;
      last_out    <= last_read;
    end else if (consume) begin
      valid_out   <= 1'b0;
      last_out    <= 1'b0;
    end
  end

`ifdef REPETITION_DETECTOR_STATS_EN
  function automatic logic [31:0] popcount(input logic [ZERO_INFO-1:0] v);
    logic [31:0] c;
    c = '0;
    for (int k = 0; k < ZERO_INFO; k++) c = c + 32'(v[k]);
    return c;
  endfunction

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

  // Statistics counters. They advance on each consumed output group and saturate at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_info_count  <= '0;
      stat_group_count <= '0;
    end else if (cfg_accept) begin
      stat_info_count  <= '0;
      stat_group_count <= '0;
    end else if (consume) begin
      stat_info_count  <= sat_add32(stat_info_count, popcount(data_out[VW +: ZERO_INFO]));
      stat_group_count <= sat_add32(stat_group_count, 32'd1);
    end
  end
`endif

endmodule

// File: tb/tb_repetition_detector_v2.sv
// Directed testbench for repetition_detector_v2 (default parameters, stats disabled).
module tb_repetition_detector_v2;

  logic        clk;
  logic        rst;
  logic        configure;
  logic        mode;
  logic [15:0] num_iters;
  logic [15:0] num_reads_per_iter;
  logic [31:0] data_in;
  logic        valid_in;
  logic        avail_out;
  logic [35:0] data_out;
  logic [7:0]  rep_idx_out;
  logic        valid_out;
  logic        last_out;
  logic        done;
  logic        avail_in;

  int tests = 0;
  int fails = 0;

  repetition_detector_v2 dut (
    .clk                (clk),
    .rst                (rst),
    .configure          (configure),
    .mode               (mode),
    .num_iters          (num_iters),
    .num_reads_per_iter (num_reads_per_iter),
    .data_in            (data_in),
    .valid_in           (valid_in),
    .avail_out          (avail_out),
    .data_out           (data_out),
    .rep_idx_out        (rep_idx_out),
    .valid_out          (valid_out),
    .last_out           (last_out),
    .done               (done),
    .avail_in           (avail_in)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic m, input logic [15:0] it, input logic [15:0] rd);
    mode = m;
    num_iters = it;
    num_reads_per_iter = rd;
    configure = 1'b1;
    @(posedge clk); #1;
    configure = 1'b0;
  endtask

  // Present one group, expect it accepted, then check the registered output
  task automatic send(input string tag, input logic [31:0] d, input logic [3:0] einfo,
                      input logic [7:0] eidx, input logic elast);
    data_in  = d;
    valid_in = 1'b1;
    #1;
    chk({tag, "_avail"}, 64'(avail_out), 64'd1);
    @(posedge clk); #1;
    valid_in = 1'b0;
    chk({tag, "_valid"}, 64'(valid_out), 64'd1);
    chk({tag, "_data"},  64'(data_out), 64'({einfo, d}));
    chk({tag, "_idx"},   64'(rep_idx_out), 64'(eidx));
    chk({tag, "_last"},  64'(last_out), 64'(elast));
  endtask

  initial begin
    rst = 1'b0; configure = 1'b0; mode = 1'b0; num_iters = '0; num_reads_per_iter = '0;
    data_in = '0; valid_in = 1'b0; avail_in = 1'b1;

    // Reset state
    #1;
    chk("rst_avail", 64'(avail_out), 64'd0);
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_last",  64'(last_out), 64'd0);
    chk("rst_done",  64'(done), 64'd0);
    chk("rst_data",  64'(data_out), 64'd0);
    chk("rst_idx",   64'(rep_idx_out), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_avail", 64'(avail_out), 64'd0);

    // Mode 0, one iteration of four groups
    cfg(1'b0, 16'd1, 16'd4);
    send("m0_g0", 32'h03020100, 4'b0001, 8'hE4, 1'b0);
    send("m0_g1", 32'h03020000, 4'b0011, 8'hE4, 1'b0);
    send("m0_g2", 32'h03000000, 4'b0111, 8'hE4, 1'b0);
    send("m0_g3", 32'h00000000, 4'b1111, 8'hE4, 1'b1);
    chk("m0_flush_avail", 64'(avail_out), 64'd0);
    chk("m0_flush_done",  64'(done), 64'd0);
    @(posedge clk); #1;
    chk("m0_done",       64'(done), 64'd1);
    chk("m0_done_valid", 64'(valid_out), 64'd0);
    @(posedge clk); #1;
    chk("m0_done_clr",   64'(done), 64'd0);

    // Mode 1, repetition detection
    cfg(1'b1, 16'd1, 16'd4);
    send("m1_5755", 32'h05050705, 4'b1100, 8'h04, 1'b0);
    send("m1_9999", 32'h09090909, 4'b1110, 8'h00, 1'b0);
    send("m1_0330", 32'h00030300, 4'b1100, 8'h14, 1'b0);
    send("m1_1234", 32'h04030201, 4'b0000, 8'hE4, 1'b1);
    @(posedge clk); #1;
    chk("m1_done", 64'(done), 64'd1);
    @(posedge clk); #1;

    // Backpressure
    cfg(1'b0, 16'd1, 16'd2);
    send("bp_g0", 32'h04030201, 4'b0000, 8'hE4, 1'b0);
    avail_in = 1'b0;
    data_in  = 32'h00070000;
    valid_in = 1'b1;
    #1;
    chk("bp_avail_lo", 64'(avail_out), 64'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", 64'(valid_out), 64'd1);
      chk("bp_hold_data",  64'(data_out), 64'({4'b0000, 32'h04030201}));
      chk("bp_hold_avail", 64'(avail_out), 64'd0);
    end
    avail_in = 1'b1;
    #1;
    chk("bp_avail_hi", 64'(avail_out), 64'd1);
    @(posedge clk); #1;
    valid_in = 1'b0;
    chk("bp_g1_valid", 64'(valid_out), 64'd1);
    chk("bp_g1_data",  64'(data_out), 64'({4'b1011, 32'h00070000}));
    chk("bp_g1_last",  64'(last_out), 64'd1);
    avail_in = 1'b0;
    @(posedge clk); #1;
    chk("bp_flush_wait", 64'(done), 64'd0);
    chk("bp_flush_hold", 64'(valid_out), 64'd1);
    avail_in = 1'b1;
    @(posedge clk); #1;
    chk("bp_done", 64'(done), 64'd1);
    @(posedge clk); #1;

    // Two iterations of three groups
    cfg(1'b0, 16'd2, 16'd3);
    for (int g = 0; g < 6; g++) begin
      send("it_g", 32'h11223344 + 32'(g), 4'b0000, 8'hE4, (g == 2) || (g == 5));
    end
    valid_in = 1'b1;
    data_in  = 32'h55555555;
    #1;
    chk("it_7th_avail", 64'(avail_out), 64'd0);
    @(posedge clk); #1;
    chk("it_7th_valid", 64'(valid_out), 64'd0);
    chk("it_done",      64'(done), 64'd1);
    valid_in = 1'b0;
    @(posedge clk); #1;
    chk("it_done_clr",  64'(done), 64'd0);

    // Zero iteration count goes straight to DONE for one cycle
    cfg(1'b0, 16'd0, 16'd5);
    chk("z_done",  64'(done), 64'd1);
    chk("z_avail", 64'(avail_out), 64'd0);
    chk("z_valid", 64'(valid_out), 64'd0);
    @(posedge clk); #1;
    chk("z_done_clr", 64'(done), 64'd0);
    chk("z_valid2",   64'(valid_out), 64'd0);

    // Reset mid-operation, then restart
    cfg(1'b0, 16'd1, 16'd4);
    send("rm_g0", 32'h01010101, 4'b0000, 8'hE4, 1'b0);
    send("rm_g1", 32'h02020202, 4'b0000, 8'hE4, 1'b0);
    rst = 1'b0;
    #1;
    chk("rm_valid", 64'(valid_out), 64'd0);
    chk("rm_avail", 64'(avail_out), 64'd0);
    chk("rm_done",  64'(done), 64'd0);
    chk("rm_data",  64'(data_out), 64'd0);
    #2;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rm_idle_avail", 64'(avail_out), 64'd0);
    cfg(1'b0, 16'd1, 16'd2);
    send("rs_g0", 32'h00000001, 4'b1110, 8'hE4, 1'b0);
    send("rs_g1", 32'h01000000, 4'b0111, 8'hE4, 1'b1);
    @(posedge clk); #1;
    chk("rs_done", 64'(done), 64'd1);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
